// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Build option: IMEM_LOADER_CHECKSUM_EN adds the CHECK state.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 64;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
// Ports: clk, reset (async, high), clear, shift_en, byte_in -> word, complete.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        complete
);

    logic [1:0] count;

    // complete marks the edge that consumes the last byte of a word
    assign complete = shift_en && (count == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (shift_en) begin
            word  <= {word[23:0], byte_in};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory while holding the core in reset.
// Ports: clk, reset (async, high), start, len, in_valid/in_data/in_ready byte
// stream, wr_en/wr_addr/wr_data memory write, core_reset, busy, done, err.
// Build option: IMEM_LOADER_CHECKSUM_EN enables the trailing checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LEN_W = ADDR_W + 1;

    state_t            state;
    state_t            state_n;
    logic [LEN_W-1:0]  eff_len;
    logic [LEN_W-1:0]  start_len;
    logic [ADDR_W-1:0] idx;
    logic              fire;
    logic              shift_en;
    logic              clear;
    logic              complete;
    logic              last_word;
    logic [31:0]       word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign fire     = in_valid && in_ready;
    assign shift_en = fire && (state == S_RECV);
    assign clear    = start &&
                      (state inside {S_IDLE, S_DONE, S_ERR});
    assign last_word = (LEN_W'(idx) + LEN_W'(1)) == eff_len;

    // zero or oversize requests load the whole memory
    always_comb begin
        start_len = LEN_W'(len);
        if (len == 7'd0 || 32'(len) > DEPTH)
            start_len = LEN_W'(DEPTH);
    end

    word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .shift_en (shift_en),
        .byte_in  (in_data),
        .word     (word),
        .complete (complete)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start)
                    state_n = S_RECV;
            end
            S_RECV: begin
                if (complete)
                    state_n = S_WRITE;
            end
            S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_n = last_word ? S_CHECK : S_RECV;
`else
                state_n = last_word ? S_DONE : S_RECV;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (fire)
                    state_n = (8'(sum + in_data) == 8'h00) ?
                              S_DONE : S_ERR;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            idx        <= '0;
            eff_len    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            wr_en      <= (state_n == S_WRITE);
            done       <= (state_n == S_DONE);
            core_reset <= (state_n != S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready   <= (state_n == S_RECV) ||
                          (state_n == S_CHECK);
            busy       <= (state_n == S_RECV) ||
                          (state_n == S_WRITE) ||
                          (state_n == S_CHECK);
            err_q      <= (state_n == S_ERR);
            if (clear)
                sum <= '0;
            else if (shift_en)
                sum <= sum + in_data;
`else
            in_ready   <= (state_n == S_RECV);
            busy       <= (state_n == S_RECV) ||
                          (state_n == S_WRITE);
`endif
            if (clear) begin
                eff_len <= start_len;
                idx     <= '0;
            end else if (state == S_WRITE && !last_word) begin
                idx <= idx + 1'b1;
            end
            // the word register updates on this same edge, so
            // capture the assembled word including the incoming byte
            if (state_n == S_WRITE) begin
                wr_addr <= idx;
                wr_data <= {word[23:0], in_data};
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader.
// Expected writes are queued as bytes are driven and checked on wr_en.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    bit stall_mode = 1'b0;

    logic [37:0] exp_q[$];
    logic [37:0] e;
    logic [31:0] wbuf[64];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && wr_en) begin
            wr_cnt++;
            check("wr_in_ready", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[37:32]));
                check("wr_data", wr_data, e[31:0]);
            end
        end
    end

    function automatic int eff(input int l);
        return (l == 0 || l > 64) ? 64 : l;
    endfunction

    task automatic pulse_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = 7'(l);
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_core_reset", 32'(core_reset), 32'd1);
        check("start_done", 32'(done), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (stall_mode) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready)
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!(done || err))
            check("end_timeout", 32'(done | err), 32'd1);
    endtask

    task automatic run_load(input int l, input bit pulse_mid);
        int n;
        logic [7:0] b;
        logic [7:0] sum;
        n   = eff(l);
        sum = 8'h00;
        pulse_start(l);
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({6'(w), wbuf[w]});
            for (int i = 0; i < 4; i++) begin
                b   = wbuf[w][31-8*i -: 8];
                sum = sum + b;
                send_byte(b);
                if (pulse_mid && w == 0 && i == 1) begin
                    start = 1'b1;
                    len   = 7'd5;
                    @(negedge clk);
                    start = 1'b0;
                    check("mid_start_busy", 32'(busy), 32'd1);
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum);
`endif
        wait_end();
        check("load_done", 32'(done), 32'd1);
        check("load_err", 32'(err), 32'd0);
        check("load_core_reset", 32'(core_reset), 32'd0);
        check("load_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int c0;
        reset    = 1'b1;
        start    = 1'b0;
        len      = 7'd0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic two-word load
        wbuf[0] = 32'h20080005;
        wbuf[1] = 32'h00000000;
        c0 = wr_cnt;
        run_load(2, 1'b0);
        check("basic_writes", 32'(wr_cnt - c0), 32'd2);

        // restart from DONE with an ignored start mid-load
        wbuf[0] = 32'hDEADBEEF;
        wbuf[1] = 32'h12345678;
        c0 = wr_cnt;
        run_load(2, 1'b1);
        check("mid_writes", 32'(wr_cnt - c0), 32'd2);

        // len=0 loads the whole memory
        for (int i = 0; i < 64; i++)
            wbuf[i] = $urandom;
        c0 = wr_cnt;
        run_load(0, 1'b0);
        check("full_writes", 32'(wr_cnt - c0), 32'd64);

        // oversize length clamps to DEPTH
        c0 = wr_cnt;
        run_load(70, 1'b0);
        check("clamp_writes", 32'(wr_cnt - c0), 32'd64);

        // alternating valid gives the same words
        wbuf[0] = 32'h20080005;
        wbuf[1] = 32'h00000000;
        stall_mode = 1'b1;
        c0 = wr_cnt;
        run_load(2, 1'b0);
        stall_mode = 1'b0;
        check("stall_writes", 32'(wr_cnt - c0), 32'd2);

        // reset after the sixth byte of a three-word load
        wbuf[0] = 32'hA1B2C3D4;
        wbuf[1] = 32'h55667788;
        wbuf[2] = 32'h99AABBCC;
        c0 = wr_cnt;
        pulse_start(3);
        exp_q.push_back({6'd0, wbuf[0]});
        for (int i = 0; i < 4; i++)
            send_byte(wbuf[0][31-8*i -: 8]);
        send_byte(wbuf[1][31:24]);
        send_byte(wbuf[1][23:16]);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_core_reset", 32'(core_reset), 32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_wr_en", 32'(wr_en), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (12) @(negedge clk);
        in_valid = 1'b0;
        check("abort_writes", 32'(wr_cnt - c0), 32'd1);
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // good checksum
        wbuf[0] = 32'h01020304;
        pulse_start(1);
        exp_q.push_back({6'd0, wbuf[0]});
        for (int i = 0; i < 4; i++)
            send_byte(wbuf[0][31-8*i -: 8]);
        send_byte(8'hF6);
        wait_end();
        check("csum_ok_done", 32'(done), 32'd1);
        check("csum_ok_err", 32'(err), 32'd0);
        // bad checksum
        pulse_start(1);
        exp_q.push_back({6'd0, wbuf[0]});
        for (int i = 0; i < 4; i++)
            send_byte(wbuf[0][31-8*i -: 8]);
        send_byte(8'hF7);
        wait_end();
        check("csum_bad_err", 32'(err), 32'd1);
        check("csum_bad_done", 32'(done), 32'd0);
        check("csum_bad_core_reset", 32'(core_reset), 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
